guineveer_mbox_monitor: RTL
===========================

// Module: guineveer_mbox_monitor
// PURPOSE
// - Multi-channel AXI write-snooping mailbox monitor; successor of the single-address tb console/pass/fail check.
// - Passively observes one AXI4 AW/W pair (e.g. LSU port) and decodes writes to NUM_CH mailbox addresses.
// - Per channel: printable bytes -> shared console char stream; 0xFF = channel pass; 0x01 = channel fail.
// - Aggregates channel status into done/pass/fail; optional cycle watchdog. Never drives the bus.
// PARAMETERS
// - ADDR_W       32           AXI address width
// - DATA_W       64           AXI data width (multiple of 8, >= 8)
// - NUM_CH       2            mailbox channel count (1..8)
// - MBOX_BASE    'h80f80000   address of channel 0
// - MBOX_STRIDE  'h8          address step between channels
// - PEND_DEPTH   4            depth of AW and W pending FIFOs (power of 2)
// - CHAR_DEPTH   16           depth of console char FIFO (power of 2)
// - MAX_CYCLES   99_000_000   watchdog limit (used only with the macro)
// - Local: CH_W = max(1, $clog2(NUM_CH))
// PORTS
// - clk_i         in   1          core clock
// - rst_ni        in   1          async active-low reset
// - aw_valid_i    in   1          snooped AWVALID
// - aw_ready_i    in   1          snooped AWREADY
// - aw_addr_i     in   ADDR_W     snooped AWADDR
// - w_valid_i     in   1          snooped WVALID
// - w_ready_i     in   1          snooped WREADY
// - w_data_i      in   DATA_W     snooped WDATA
// - w_strb_i      in   DATA_W/8   snooped WSTRB
// - char_valid_o  out  1          console byte available
// - char_ready_i  in   1          consumer accepts byte
// - char_data_o   out  8          console byte
// - char_chan_o   out  CH_W       channel that produced byte
// - done_o        out  1          test finished (sticky)
// - pass_o        out  1          all channels passed (sticky)
// - fail_o        out  1          a channel failed or watchdog fired (sticky)
// - fail_chan_o   out  CH_W       lowest-index failing channel
// - timeout_o     out  1          watchdog fired (sticky)
// - overflow_o    out  1          any pending/char FIFO overflow (sticky)
// - cycle_cnt_o   out  32         cycles since reset release, saturating
// BEHAVIOUR
// - Clock clk_i; reset rst_ni asynchronous, active-low; all outputs and FIFOs 0/empty while reset asserted.
// - Reset mid-operation: all state cleared immediately; pending beats and chars discarded.
// - AW beat = aw_valid_i & aw_ready_i -> push aw_addr_i to AW FIFO; W beat = w_valid_i & w_ready_i -> push data/strb.
// - Single-beat transactions only; pairing is in order: pop one AW + one W when both available.
// - Bypass: same-cycle AW and W beats with both FIFOs empty pair directly; no FIFO entry used.
// - FIFO full on push: beat dropped, overflow_o=1; pairing continues with remaining entries.
// - Pair match: addr == MBOX_BASE + i*MBOX_STRIDE (full ADDR_W compare) and w_strb[0]=1; byte = w_data[7:0].
// - Non-matching pair or strb[0]=0: discarded, no side effect.
// - Classify (registered, 1 cycle after pairing):
//   - byte 0x06..0x7E -> push {i, byte} to char FIFO; FIFO full -> byte dropped, overflow_o=1.
//   - byte 0xFF -> ch_pass[i]=1.  byte 0x01 -> ch_fail[i]=1.  others ignored.
// - Status (registered, 1 cycle after classify): any ch_fail -> done_o=fail_o=1, fail_chan_o = lowest failing index.
// - All ch_pass set and no ch_fail -> done_o=pass_o=1. pass_o and fail_o never both 1; first to set wins, frozen.
// - After done_o: status frozen; chars still accepted into FIFO.
// - Char output: valid/ready; data/chan held stable while valid & !ready; empty FIFO push -> char_valid_o next cycle.
// - Simultaneous push and pop on full char FIFO: pop succeeds, push accepted, no overflow.
// - cycle_cnt_o: +1 per cycle from reset release; saturates at 32'hFFFF_FFFF.
// CONFIGURATION
// - GUINEVEER_MBOX_MON_TIMEOUT_EN defined: when cycle_cnt_o == MAX_CYCLES and done_o=0 -> next cycle
//   timeout_o=done_o=fail_o=1, fail_chan_o=0; status then frozen.
// - Undefined: no watchdog logic; timeout_o tied 0; done only via mailbox bytes.
// TESTING
// - Write 'h48 to 'h80f80000 (AW then W 3 cycles later) -> char_valid_o, data 'h48, chan 0; no status change.
// - Ch0 0xFF, then ch1 0xFF -> done_o=pass_o=1 two cycles after second pair; fail_o=0.
// - Ch1 0x01, then ch0 0xFF -> fail_o=1, fail_chan_o=1, pass_o stays 0 forever.
// - 17 printable writes, char_ready_i=0 -> 16 buffered, overflow_o=1; drain yields first 16 in order.
// - 5 AW beats, no W -> overflow_o=1; then 4 W beats pair with first 4 addresses in order.
// - Macro on, MAX_CYCLES=100, no writes -> timeout_o=done_o=fail_o=1 at cycle 101; macro off -> stays 0.

Source files
------------

// File: rtl/guineveer_mbox_monitor.sv
// guineveer_mbox_monitor
//   Passive AXI4 write snooper that decodes single-beat writes to NUM_CH
//   mailbox addresses (MBOX_BASE + i*MBOX_STRIDE). Printable bytes go to a
//   shared console char stream; 0xFF marks a channel passed, 0x01 failed.
//   Channel status is folded into sticky done/pass/fail flags.
//   Optional watchdog: define GUINEVEER_MBOX_MON_TIMEOUT_EN to enable.
//   Depths PEND_DEPTH and CHAR_DEPTH must be powers of two, >= 2.
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   aw_valid_i/aw_ready_i/aw_addr_i      snooped AW channel
//   w_valid_i/w_ready_i/w_data_i/w_strb_i snooped W channel
//   char_valid_o/char_ready_i/char_data_o/char_chan_o  console byte stream
//   done_o, pass_o, fail_o, fail_chan_o  sticky test status
//   timeout_o                     watchdog fired (sticky)
//   overflow_o                    any FIFO dropped a beat/byte (sticky)
//   cycle_cnt_o                   saturating cycles since reset release
module guineveer_mbox_monitor #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 64,
    parameter int                NUM_CH      = 2,
    parameter logic [ADDR_W-1:0] MBOX_BASE   = 'h80f80000,
    parameter logic [ADDR_W-1:0] MBOX_STRIDE = 'h8,
    parameter int                PEND_DEPTH  = 4,
    parameter int                CHAR_DEPTH  = 16,
    parameter int                MAX_CYCLES  = 99_000_000,
    localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_valid_i,
    input  logic                aw_ready_i,
    input  logic [ADDR_W-1:0]   aw_addr_i,
    input  logic                w_valid_i,
    input  logic                w_ready_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    output logic                char_valid_o,
    input  logic                char_ready_i,
    output logic [7:0]          char_data_o,
    output logic [CH_W-1:0]     char_chan_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                fail_o,
    output logic [CH_W-1:0]     fail_chan_o,
    output logic                timeout_o,
    output logic                overflow_o,
    output logic [31:0]         cycle_cnt_o
);
    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = $clog2(CHAR_DEPTH);

    // Storage: W entries keep only {strb[0], data[7:0]}, all that decode needs.
    logic [ADDR_W-1:0] aw_mem_q   [PEND_DEPTH];
    logic [8:0]        w_mem_q    [PEND_DEPTH];
    logic [CH_W+7:0]   char_mem_q [CHAR_DEPTH];

    logic [PW-1:0] aw_wr_ptr_q, aw_wr_ptr_d, aw_rd_ptr_q, aw_rd_ptr_d;
    logic [PW-1:0] w_wr_ptr_q, w_wr_ptr_d, w_rd_ptr_q, w_rd_ptr_d;
    logic [PW:0]   aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
    logic [CW-1:0] char_wr_ptr_q, char_wr_ptr_d, char_rd_ptr_q, char_rd_ptr_d;
    logic [CW:0]   char_cnt_q, char_cnt_d;

    logic              cls_valid_q, cls_valid_d;
    logic [CH_W-1:0]   cls_ch_q, cls_ch_d;
    logic [7:0]        cls_byte_q, cls_byte_d;
    logic [NUM_CH-1:0] ch_pass_q, ch_pass_d, ch_fail_q, ch_fail_d;
    logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic [CH_W-1:0]   fail_chan_q, fail_chan_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
    logic              timeout_q, timeout_d;
`endif

    logic              aw_beat, w_beat, aw_empty, w_empty, aw_full, w_full;
    logic              bypass, pair_pop, aw_wr_en, w_wr_en;
    logic [ADDR_W-1:0] pair_addr;
    logic [8:0]        pair_w;
    logic              char_push, char_pop, char_full, char_wr_en;
    logic [NUM_CH-1:0] ch_oh;
    logic              unused_sink;

    assign aw_beat  = aw_valid_i & aw_ready_i;
    assign w_beat   = w_valid_i & w_ready_i;
    assign aw_empty = (aw_cnt_q == '0);
    assign w_empty  = (w_cnt_q == '0);
    assign aw_full  = (aw_cnt_q == (PW+1)'(PEND_DEPTH));
    assign w_full   = (w_cnt_q == (PW+1)'(PEND_DEPTH));

    // Same-cycle beats with nothing queued pair directly and never touch the FIFOs.
    assign bypass    = aw_beat & w_beat & aw_empty & w_empty;
    assign pair_pop  = !aw_empty & !w_empty;
    assign pair_addr = bypass ? aw_addr_i : aw_mem_q[aw_rd_ptr_q];
    assign pair_w    = bypass ? {w_strb_i[0], w_data_i[7:0]} : w_mem_q[w_rd_ptr_q];
    // A push into a full FIFO still fits when the head pops in the same cycle.
    assign aw_wr_en  = aw_beat & !bypass & (!aw_full | pair_pop);
    assign w_wr_en   = w_beat & !bypass & (!w_full | pair_pop);

    assign char_valid_o = (char_cnt_q != '0);
    assign char_pop     = char_valid_o & char_ready_i;
    assign char_full    = (char_cnt_q == (CW+1)'(CHAR_DEPTH));
    assign char_push    = cls_valid_q & (cls_byte_q >= 8'h06) & (cls_byte_q <= 8'h7E);
    assign char_wr_en   = char_push & (!char_full | char_pop);
    // Gate with valid so the outputs read 0 in reset and when empty.
    assign {char_chan_o, char_data_o} = char_valid_o ? char_mem_q[char_rd_ptr_q] : '0;
    assign ch_oh = NUM_CH'(1) << cls_ch_q;

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign fail_chan_o = fail_chan_q;
    assign overflow_o  = overflow_q;
    assign cycle_cnt_o = cycle_cnt_q;
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif
    // Only the low byte and strobe bit 0 are decoded; the rest is ignored.
    assign unused_sink = ^{w_data_i, w_strb_i, MAX_CYCLES};

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        aw_wr_ptr_d   = aw_wr_ptr_q + PW'(aw_wr_en);
        aw_rd_ptr_d   = aw_rd_ptr_q + PW'(pair_pop);
        aw_cnt_d      = aw_cnt_q + (PW+1)'(aw_wr_en) - (PW+1)'(pair_pop);
        w_wr_ptr_d    = w_wr_ptr_q + PW'(w_wr_en);
        w_rd_ptr_d    = w_rd_ptr_q + PW'(pair_pop);
        w_cnt_d       = w_cnt_q + (PW+1)'(w_wr_en) - (PW+1)'(pair_pop);
        char_wr_ptr_d = char_wr_ptr_q + CW'(char_wr_en);
        char_rd_ptr_d = char_rd_ptr_q + CW'(char_pop);
        char_cnt_d    = char_cnt_q + (CW+1)'(char_wr_en) - (CW+1)'(char_pop);
        overflow_d    = overflow_q
                      | (aw_beat & !bypass & !aw_wr_en)
                      | (w_beat & !bypass & !w_wr_en)
                      | (char_push & !char_wr_en);
        cycle_cnt_d   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 32'd1;

        // Pair stage: full-width address decode against every mailbox.
        cls_valid_d = 1'b0;
        cls_ch_d    = '0;
        cls_byte_d  = pair_w[7:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if ((bypass | pair_pop) && pair_w[8] &&
                pair_addr == MBOX_BASE + ADDR_W'(i) * MBOX_STRIDE) begin
                cls_valid_d = 1'b1;
                cls_ch_d    = CH_W'(i);
            end
        end

        // Classify stage.
        ch_pass_d = ch_pass_q;
        ch_fail_d = ch_fail_q;
        if (cls_valid_q && cls_byte_q == 8'hFF) ch_pass_d = ch_pass_q | ch_oh;
        if (cls_valid_q && cls_byte_q == 8'h01) ch_fail_d = ch_fail_q | ch_oh;

        // Status stage: whichever verdict lands first freezes everything.
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_chan_d = fail_chan_q;
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        if (!done_q) begin
            if (|ch_fail_q) begin
                done_d = 1'b1;
                fail_d = 1'b1;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (ch_fail_q[i]) fail_chan_d = CH_W'(i);
                end
            end else if (&ch_pass_q) begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
            else if (cycle_cnt_q == 32'(MAX_CYCLES)) begin
                done_d      = 1'b1;
                fail_d      = 1'b1;
                timeout_d   = 1'b1;
                fail_chan_d = '0;
            end
`endif
        end
    end

    // NOTE: FIFO storage is not reset; pointers and counts define emptiness,
    // so clearing the arrays would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (aw_wr_en)   aw_mem_q[aw_wr_ptr_q]     <= aw_addr_i;
        if (w_wr_en)    w_mem_q[w_wr_ptr_q]       <= {w_strb_i[0], w_data_i[7:0]};
        if (char_wr_en) char_mem_q[char_wr_ptr_q] <= {cls_ch_q, cls_byte_q};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_wr_ptr_q   <= '0;
            aw_rd_ptr_q   <= '0;
            aw_cnt_q      <= '0;
            w_wr_ptr_q    <= '0;
            w_rd_ptr_q    <= '0;
            w_cnt_q       <= '0;
            char_wr_ptr_q <= '0;
            char_rd_ptr_q <= '0;
            char_cnt_q    <= '0;
            cls_valid_q   <= 1'b0;
            cls_ch_q      <= '0;
            cls_byte_q    <= '0;
            ch_pass_q     <= '0;
            ch_fail_q     <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_chan_q   <= '0;
            overflow_q    <= 1'b0;
            cycle_cnt_q   <= '0;
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            aw_wr_ptr_q   <= aw_wr_ptr_d;
            aw_rd_ptr_q   <= aw_rd_ptr_d;
            aw_cnt_q      <= aw_cnt_d;
            w_wr_ptr_q    <= w_wr_ptr_d;
            w_rd_ptr_q    <= w_rd_ptr_d;
            w_cnt_q       <= w_cnt_d;
            char_wr_ptr_q <= char_wr_ptr_d;
            char_rd_ptr_q <= char_rd_ptr_d;
            char_cnt_q    <= char_cnt_d;
            cls_valid_q   <= cls_valid_d;
            cls_ch_q      <= cls_ch_d;
            cls_byte_q    <= cls_byte_d;
            ch_pass_q     <= ch_pass_d;
            ch_fail_q     <= ch_fail_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_chan_q   <= fail_chan_d;
            overflow_q    <= overflow_d;
            cycle_cnt_q   <= cycle_cnt_d;
`ifdef GUINEVEER_MBOX_MON_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

endmodule
